// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA timing generator and the renderers.
// Default constants describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef logic [COORD_W-1:0] vga_coord_t;

  // True when lo <= v < lo+len; compared as int so spans ending at 1024 still work.
  function automatic logic in_span(vga_coord_t v, int lo, int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo counter for one raster axis; wrap flags the increment that returns it to zero.
// count_next is exported so callers can decode the upcoming position into registers.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Modulus = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output vga_coord_t count,
  output vga_coord_t count_next,
  output logic       wrap
);

  localparam vga_coord_t Last = vga_coord_t'(Modulus - 1);

  assign wrap = inc && (count == Last);

  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: walks (DrawX, DrawY) over the whole frame and registers decodes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               frame_start,
  output logic               line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  vga_coord_t h_next, v_next;
  logic       h_wrap, v_wrap;

  vga_wrap_counter #(
    .Modulus(H_TOTAL)
  ) u_h_cnt (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .inc       (1'b1),
    .count     (DrawX),
    .count_next(h_next),
    .wrap      (h_wrap)
  );

  vga_wrap_counter #(
    .Modulus(V_TOTAL)
  ) u_v_cnt (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .inc       (h_wrap),
    .count     (DrawY),
    .count_next(v_next),
    .wrap      (v_wrap)
  );

  // Decoding the next position keeps every registered output aligned with DrawX/DrawY.
  logic blank_d, hs_d, vs_d, frame_start_d, line_start_d;

  always_comb begin
    blank_d       = (int'(h_next) < H_VISIBLE) && (int'(v_next) < V_VISIBLE);
    hs_d          = !in_span(h_next, H_VISIBLE + H_FRONT, H_SYNC);
    vs_d          = !in_span(v_next, V_VISIBLE + V_FRONT, V_SYNC);
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b1;
      line_start  <= 1'b1;
    end else begin
      blank       <= blank_d;
      hs          <= hs_d;
      vs          <= vs_d;
      frame_start <= frame_start_d;
      line_start  <= line_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance plus a shrunken-timing instance for whole frames.
// Stimulus pushes expected raster state each cycle; a negedge monitor pops and compares.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 vga_clk = ~vga_clk;

  vga_coord_t x_a, y_a, x_b, y_b;
  logic blank_a, hs_a, vs_a, fs_a, ls_a;
  logic blank_b, hs_b, vs_b, fs_b, ls_b;
  logic [15:0] fc_a, fc_b;

  vga_timing_gen u_dut_a (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (x_a),
    .DrawY      (y_a),
    .blank      (blank_a),
    .hs         (hs_a),
    .vs         (vs_a),
    .frame_start(fs_a),
    .line_start (ls_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_count(fc_a)
`endif
  );

  // Small timing: H 16+2+4+3 = 25, V 10+2+2+3 = 17, frame = 425 cycles.
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_dut_b (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (x_b),
    .DrawY      (y_b),
    .blank      (blank_b),
    .hs         (hs_b),
    .vs         (vs_b),
    .frame_start(fs_b),
    .line_start (ls_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_count(fc_b)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_a = '0;
  assign fc_b = '0;
`endif

  typedef struct {
    bit dut;
    bit directed;
    int k;
    int x;
    int y;
    bit b;
    bit hs;
    bit vs;
    bit fs;
    bit ls;
    int fc;
  } exp_t;

  exp_t q[$];
  exp_t dir_tab[$];
  int checks = 0;
  int failures = 0;

  int hv [2] = '{640, 16};
  int hf [2] = '{16, 2};
  int hsy[2] = '{96, 4};
  int hb [2] = '{48, 3};
  int vv [2] = '{480, 10};
  int vf [2] = '{10, 2};
  int vsy[2] = '{2, 2};
  int vb [2] = '{33, 3};
  int mx[2], my[2], mfc[2];
  int k = 0;
  bit first_run = 1'b0;

  function automatic exp_t mk(bit d, int kk, int x, int y, bit b, bit hs, bit vs, bit fs, bit ls,
                              int fc);
    exp_t e;
    e.dut = d; e.directed = 1'b1; e.k = kk; e.x = x; e.y = y;
    e.b = b; e.hs = hs; e.vs = vs; e.fs = fs; e.ls = ls; e.fc = fc;
    return e;
  endfunction

  function automatic exp_t model_entry(int d);
    exp_t e;
    e.dut = d[0]; e.directed = 1'b0; e.k = k; e.x = mx[d]; e.y = my[d];
    e.b  = (mx[d] < hv[d]) && (my[d] < vv[d]);
    e.hs = !((mx[d] >= hv[d] + hf[d]) && (mx[d] < hv[d] + hf[d] + hsy[d]));
    e.vs = !((my[d] >= vv[d] + vf[d]) && (my[d] < vv[d] + vf[d] + vsy[d]));
    e.fs = (mx[d] == 0) && (my[d] == 0);
    e.ls = (mx[d] == 0);
    e.fc = mfc[d] % 65536;
    return e;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; mfc[d] = 0;
    end
  endtask

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      if (mx[d] == hv[d] + hf[d] + hsy[d] + hb[d] - 1) begin
        mx[d] = 0;
        if (my[d] == vv[d] + vf[d] + vsy[d] + vb[d] - 1) begin
          my[d] = 0;
          mfc[d]++;
        end else begin
          my[d]++;
        end
      end else begin
        mx[d]++;
      end
    end
  endtask

  task automatic push_directed(int kk);
    foreach (dir_tab[i]) if (dir_tab[i].k == kk) q.push_back(dir_tab[i]);
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    if (reset_n) begin
      k++;
      model_advance();
    end else begin
      model_clear();
    end
    q.push_back(model_entry(0));
    q.push_back(model_entry(1));
    if (reset_n) push_directed(k);
  endtask

  task automatic release_reset();
    step();
    #2;
    reset_n = 1'b1;
    k = 0;
    push_directed(0);
  endtask

  // Reset lands between edges; the following negedge sees reset values with no edge in between.
  task automatic mid_reset();
    @(posedge vga_clk);
    #2;
    reset_n = 1'b0;
    first_run = 1'b0;
    model_clear();
    q.push_back(model_entry(0));
    q.push_back(model_entry(1));
    q.push_back(mk(0, -1, 0, 0, 1, 1, 1, 1, 1, 0));
    q.push_back(mk(1, -1, 0, 0, 1, 1, 1, 1, 1, 0));
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Monitor: measurements over the first run, then scoreboard comparison.
  int ncyc = 0;
  int hs_low_a = 0, vs_low_b = 0;
  int fs_n = 0, fs_t0 = 0, fs_t1 = 0;
  int ls_n = 0, ls_t0 = 0, ls_t1 = 0;

  initial begin
    forever begin
      @(negedge vga_clk);
      ncyc++;
      if (first_run) begin
        if (fs_b === 1'b1) begin
          if (fs_n == 0) fs_t0 = ncyc;
          else if (fs_n == 1) fs_t1 = ncyc;
          fs_n++;
        end
        if (fs_n == 1 && vs_b === 1'b0) vs_low_b++;
        if (ls_a === 1'b1) begin
          if (ls_n == 0) ls_t0 = ncyc;
          else if (ls_n == 1) ls_t1 = ncyc;
          ls_n++;
        end
        if (y_a == 0 && hs_a === 1'b0) hs_low_a++;
      end
      while (q.size() > 0) begin
        exp_t e;
        int ax, ay, afc;
        logic ab, ahs, avs, afs, als;
        bit ok;
        e = q.pop_front();
        ax  = e.dut ? int'(x_b) : int'(x_a);
        ay  = e.dut ? int'(y_b) : int'(y_a);
        ab  = e.dut ? blank_b : blank_a;
        ahs = e.dut ? hs_b : hs_a;
        avs = e.dut ? vs_b : vs_a;
        afs = e.dut ? fs_b : fs_a;
        als = e.dut ? ls_b : ls_a;
        afc = e.dut ? int'(fc_b) : int'(fc_a);
        ok = (ax === e.x) && (ay === e.y) && (ab === e.b) && (ahs === e.hs) && (avs === e.vs) &&
             (afs === e.fs) && (als === e.ls);
`ifdef VGA_TIMING_FRAME_CNT_EN
        ok = ok && (afc === e.fc);
`endif
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s k=%0d dut=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b ls=%b fc=%0d %s",
                   e.directed ? "vector" : "model", e.k, e.dut, ax, ay, ab, ahs, avs, afs, als, afc,
                   $sformatf("expected x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b ls=%b fc=%0d",
                             e.x, e.y, e.b, e.hs, e.vs, e.fs, e.ls, e.fc));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Default 640x480 instance: hand-computed positions across line 0 and the first wrap.
    dir_tab.push_back(mk(0, 0,   0,   0, 1, 1, 1, 1, 1, 0));
    dir_tab.push_back(mk(0, 1,   1,   0, 1, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 639, 639, 0, 1, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 640, 640, 0, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 655, 655, 0, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 656, 656, 0, 0, 0, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 751, 751, 0, 0, 0, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 752, 752, 0, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 799, 799, 0, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(0, 800, 0,   1, 1, 1, 1, 0, 1, 0));
    // Small instance: sync at x 18..21 and lines 12..13, frame wrap at k=425.
    dir_tab.push_back(mk(1, 0,   0,  0,  1, 1, 1, 1, 1, 0));
    dir_tab.push_back(mk(1, 16,  16, 0,  0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 18,  18, 0,  0, 0, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 21,  21, 0,  0, 0, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 22,  22, 0,  0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 25,  0,  1,  1, 1, 1, 0, 1, 0));
    dir_tab.push_back(mk(1, 250, 0,  10, 0, 1, 1, 0, 1, 0));
    dir_tab.push_back(mk(1, 299, 24, 11, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 300, 0,  12, 0, 1, 0, 0, 1, 0));
    dir_tab.push_back(mk(1, 349, 24, 13, 0, 1, 0, 0, 0, 0));
    dir_tab.push_back(mk(1, 350, 0,  14, 0, 1, 1, 0, 1, 0));
    dir_tab.push_back(mk(1, 424, 24, 16, 0, 1, 1, 0, 0, 0));
    dir_tab.push_back(mk(1, 425, 0,  0,  1, 1, 1, 1, 1, 1));
    dir_tab.push_back(mk(1, 441, 16, 0,  0, 1, 1, 0, 0, 1));
    dir_tab.push_back(mk(1, 850, 0,  0,  1, 1, 1, 1, 1, 2));
    dir_tab.push_back(mk(1, 1275, 0, 0,  1, 1, 1, 1, 1, 3));

    model_clear();
    #1;
    reset_n = 1'b0;
    repeat (3) step();
    release_reset();
    first_run = 1'b1;
    // Four small frames and default position (300,2) at the mid-frame reset.
    repeat (1899) step();
    mid_reset();
    repeat (2) step();
    release_reset();
    repeat (450) step();
    @(negedge vga_clk);
    #1;

    chk("queue_drained", q.size(), 0);
    chk("hs_low_cycles_line0", hs_low_a, 96);
    chk("vs_low_cycles_frame0", vs_low_b, 50);
    chk("frame_period", fs_t1 - fs_t0, 425);
    chk("line_period", ls_t1 - ls_t0, 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator driving the raster interface that sprite and background renderers consume: `DrawX`, `DrawY`, `blank`, plus `hs`/`vs` to the VGA connector. It runs on the pixel clock `vga_clk`, walks a horizontal and a vertical counter across the full frame (visible area plus porches and sync), and decodes sync and blanking from them. Renderers downstream register their colour on the same `vga_clk` posedge and fetch ROM data on the negedge.

## Interface
Parameters (integer, defaults give 640x480 @ 60 Hz with a 25.175 MHz pixel clock):
- `H_VISIBLE`, default 640, visible pixels per line
- `H_FRONT`, default 16, horizontal front porch
- `H_SYNC`, default 96, horizontal sync width
- `H_BACK`, default 48, horizontal back porch
- `V_VISIBLE`, default 480, visible lines per frame
- `V_FRONT`, default 10, vertical front porch
- `V_SYNC`, default 2, vertical sync width
- `V_BACK`, default 33, vertical back porch

Ports:
- `vga_clk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `DrawX`  out  10  horizontal counter, 0..H_TOTAL-1
- `DrawY`  out  10  vertical counter, 0..V_TOTAL-1
- `blank`  out  1  1 = inside the visible area (draw); 0 = blanked
- `hs`  out  1  horizontal sync, active low
- `vs`  out  1  vertical sync, active low
- `frame_start`  out  1  high exactly while `DrawX`==0 and `DrawY`==0
- `line_start`  out  1  high exactly while `DrawX`==0

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both totals must be ≤1024; a static check fails elaboration otherwise.
- Horizontal counter: increments every cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on the cycle where the horizontal counter wraps. At V_TOTAL-1, coinciding with the horizontal wrap, it wraps to 0.
- Decodes, each evaluated at counter value (x,y):
  - `blank` = (x < H_VISIBLE) && (y < V_VISIBLE)
  - `hs` = 0 iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - `vs` = 0 iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (490..491); `vs` depends on y only, for all x
  - `frame_start` and `line_start` as defined under Interface
- All outputs are flops. Decodes are computed from next-state counter values, so every output describes the same (x,y) as `DrawX`/`DrawY` on every cycle. No output glitches.
- Reset drives the counters and every output to the decode of (0,0): `DrawX`=0, `DrawY`=0, `blank`=1, `hs`=1, `vs`=1, `frame_start`=1, `line_start`=1. Assertion mid-frame restarts the frame at (0,0) immediately, with no partial line completion.

## Timing
- One (x,y) position per `vga_clk` cycle. Latency from counter to decode is zero, because outputs are aligned.
- Line period is H_TOTAL cycles (800). Frame period is H_TOTAL*V_TOTAL cycles (420000).
- After release of `reset_n`, the first posedge moves to (1,0).
- The transition (H_TOTAL-1, V_TOTAL-1) → (0,0) happens in a single edge: both counters wrap and `frame_start` rises.
- Downstream contract: a consumer that addresses a ROM from `DrawX`/`DrawY` on the negedge and registers colour gated by `blank` on the posedge gets exactly one cycle of pixel offset. That offset is accepted and is not compensated here.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - Adds output `frame_count` (out, 16) that increments on each (V_TOTAL-1, H_TOTAL-1) → (0,0) wrap.
  - It wraps 0xFFFF → 0 and resets to 0.
  - Used by animation logic.
- Undefined: the port and its register do not exist; all other behaviour is identical.

## Structure
- Shared package `vga_timing_pkg` holds:
  - default timing constants (640x480 set)
  - `COORD_W` = 10
  - a `vga_coord_t` typedef (`logic [COORD_W-1:0]`)
- The renderers import the same package.
- One sub-module, `vga_wrap_counter`: parameterised modulus, `inc` input, `wrap` output, async active-low reset. It is instantiated twice: horizontal with `inc`=1, vertical with `inc`=horizontal `wrap`.

## Test plan
- Reset held, then released → `DrawX`=0, `DrawY`=0, `blank`=1, `hs`=1, `vs`=1, `frame_start`=1. Next edge → `DrawX`=1, `frame_start`=0, `line_start`=0.
- Run one line → `blank` falls at `DrawX`=640, `hs` low for exactly 96 cycles at 656..751, `DrawX` wraps 799→0 with `DrawY` 0→1 on the same edge.
- Run one full frame → `vs` low for exactly 1600 cycles (lines 490..491), `blank` stays 0 for `DrawY` 480..524, `frame_start` is asserted again exactly 420000 cycles after the first.
- Assert `reset_n` low at (300,200) for 3 cycles, asynchronously between edges → outputs jump to the reset values immediately, and the frame restarts at (0,0) on release.
- Every cycle over two frames, a checker recomputes `blank`/`hs`/`vs`/`line_start` from `DrawX`/`DrawY` → zero mismatches.
- With `VGA_TIMING_FRAME_CNT_EN` defined, run 3 frames → `frame_count` goes 0→1→2→3, each step on the (0,0) edge.
